// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider with separate high/low phase lengths,
// edge tick strobes, a one-deep staged config port and synchronous restart.
module clk_div_prog #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_HIGH = 10,
    parameter int unsigned RESET_LOW  = 10,
    parameter logic        OUT_INIT   = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall
);

    localparam logic [CNT_W-1:0] RstHi = (RESET_HIGH == 0) ? CNT_W'(1) : CNT_W'(RESET_HIGH);
    localparam logic [CNT_W-1:0] RstLo = (RESET_LOW == 0) ? CNT_W'(1) : CNT_W'(RESET_LOW);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_len_q, hi_len_d;
    logic [CNT_W-1:0] lo_len_q, lo_len_d;
    logic [CNT_W-1:0] sh_hi_q, sh_hi_d;
    logic [CNT_W-1:0] sh_lo_q, sh_lo_d;
    logic             pending_q, pending_d;
    logic             out_q, out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;

    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] req_hi, req_lo;
    logic             xfer;
    logic             phase_end;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q       <= '0;
            hi_len_q    <= RstHi;
            lo_len_q    <= RstLo;
            sh_hi_q     <= RstHi;
            sh_lo_q     <= RstLo;
            pending_q   <= 1'b0;
            out_q       <= OUT_INIT;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_len_q    <= hi_len_d;
            lo_len_q    <= lo_len_d;
            sh_hi_q     <= sh_hi_d;
            sh_lo_q     <= sh_lo_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
        end
    end

    always_comb begin
        len       = out_q ? hi_len_q : lo_len_q;
        req_hi    = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
        req_lo    = (cfg_low == '0) ? CNT_W'(1) : cfg_low;
        xfer      = cfg_valid && !pending_q;
        phase_end = (cnt_q == len - CNT_W'(1));

        cnt_d     = cnt_q;
        hi_len_d  = hi_len_q;
        lo_len_d  = lo_len_q;
        sh_hi_d   = sh_hi_q;
        sh_lo_d   = sh_lo_q;
        pending_d = pending_q;
        out_d     = out_q;

        if (xfer) begin
            sh_hi_d = req_hi;
            sh_lo_d = req_lo;
        end

        if (restart) begin
            cnt_d     = '0;
            out_d     = OUT_INIT;
            pending_d = 1'b0;
            // A config accepted in the restart cycle bypasses the shadow stage.
            if (xfer) begin
                hi_len_d = req_hi;
                lo_len_d = req_lo;
            end else if (pending_q) begin
                hi_len_d = sh_hi_q;
                lo_len_d = sh_lo_q;
            end
        end else begin
            if (xfer) begin
                pending_d = 1'b1;
            end
            if (en) begin
                if (phase_end) begin
                    cnt_d = '0;
                    out_d = !out_q;
                    // LOW->HIGH is the period boundary where staged lengths land.
                    if (!out_q && pending_q) begin
                        hi_len_d  = sh_hi_q;
                        lo_len_d  = sh_lo_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        tick_rise_d = out_d && !out_q;
        tick_fall_d = !out_d && out_q;
    end

    always_comb begin
        clk_out   = out_q;
        tick_rise = tick_rise_q;
        tick_fall = tick_fall_q;
        cfg_ready = !pending_q;
    end

endmodule
